// File: rtl/al4s3b_wb_slave_mux.sv
// Wishbone slave sequencer: routes bridge cycles to one of four FPGA slaves and returns a registered ACK.
// Optional watchdog (define WB_SLAVE_MUX_TIMEOUT_EN) force-terminates cycles a slave never acknowledges.
module al4s3b_wb_slave_mux #(
  parameter int                   ADDRWIDTH      = 10,
  parameter int                   DATAWIDTH      = 32,
  parameter logic [7:0]           TIMEOUT_CYCLES = 8'd255,
  parameter logic [DATAWIDTH-1:0] DEF_REG_VALUE  = 32'hFABDEFAC
) (
  input  logic                     WBs_CLK_i,
  input  logic                     WBs_RSTn_i,
  input  logic [ADDRWIDTH-1:0]     WBs_ADR_i,
  input  logic                     WBs_CYC_i,
  input  logic                     WBs_STB_i,
  input  logic                     WBs_WE_i,
  input  logic [3:0]               WBs_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0]     WBs_DAT_i,
  output logic [DATAWIDTH-1:0]     WBs_DAT_o,
  output logic                     WBs_ACK_o,
  output logic [ADDRWIDTH-1:0]     Slv_ADR_o,
  output logic                     Slv_WE_o,
  output logic [3:0]               Slv_BYTE_STB_o,
  output logic [DATAWIDTH-1:0]     Slv_DAT_o,
  output logic [3:0]               Slv_CYC_o,
  input  logic [3:0]               Slv_ACK_i,
  input  logic [4*DATAWIDTH-1:0]   Slv_DAT_i,
  output logic                     Timeout_o,
  output logic [1:0]               Timeout_Slv_o,
  input  logic                     Timeout_Clr_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_slv_cyc;
  logic [3:0]           w_slv_cyc_nxt;
  logic                 r_ack;
  logic                 w_ack_nxt;
  logic [DATAWIDTH-1:0] r_dat;
  logic [DATAWIDTH-1:0] w_dat_nxt;
  logic [1:0]           r_sel;
  logic [1:0]           w_sel_nxt;
  logic [1:0]           w_req_sel;
  logic [DATAWIDTH-1:0] w_sel_dat;

  assign Slv_ADR_o      = WBs_ADR_i;
  assign Slv_WE_o       = WBs_WE_i;
  assign Slv_BYTE_STB_o = WBs_BYTE_STB_i;
  assign Slv_DAT_o      = WBs_DAT_i;

  assign Slv_CYC_o = r_slv_cyc;
  assign WBs_ACK_o = r_ack;
  assign WBs_DAT_o = r_dat;

  assign w_req_sel = WBs_ADR_i[ADDRWIDTH-1 -: 2];

  always_comb begin
    w_sel_dat = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_sel == 2'(i)) w_sel_dat = Slv_DAT_i[i*DATAWIDTH +: DATAWIDTH];
    end
  end

`ifdef WB_SLAVE_MUX_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       w_cnt_clr;
  logic       w_cnt_inc;
  logic       w_to_set;
  logic       w_expired;
  logic       r_timeout;
  logic [1:0] r_timeout_slv;

  assign w_expired     = (r_cnt == (TIMEOUT_CYCLES - 8'd1));
  assign Timeout_o     = r_timeout;
  assign Timeout_Slv_o = r_timeout_slv;
`else
  logic [DATAWIDTH+8:0] w_unused_cfg;

  assign w_unused_cfg  = {Timeout_Clr_i, TIMEOUT_CYCLES, DEF_REG_VALUE};
  assign Timeout_o     = 1'b0;
  assign Timeout_Slv_o = 2'd0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_slv_cyc_nxt = r_slv_cyc;
    w_ack_nxt     = 1'b0;
    w_dat_nxt     = r_dat;
    w_sel_nxt     = r_sel;
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
    w_cnt_clr     = 1'b0;
    w_cnt_inc     = 1'b0;
    w_to_set      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (WBs_CYC_i && WBs_STB_i) begin
          w_sel_nxt     = w_req_sel;
          w_slv_cyc_nxt = 4'b0001 << w_req_sel;
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
          w_cnt_clr     = 1'b1;
`endif
          w_state_nxt   = S_BUSY;
        end
      end
      S_BUSY: begin
        // Abort beats ACK, and a slave ACK beats an expiring watchdog.
        if (!WBs_CYC_i) begin
          w_slv_cyc_nxt = 4'b0000;
          w_state_nxt   = S_IDLE;
        end else if (Slv_ACK_i[r_sel]) begin
          w_dat_nxt     = w_sel_dat;
          w_slv_cyc_nxt = 4'b0000;
          w_ack_nxt     = 1'b1;
          w_state_nxt   = S_DONE;
        end
`ifdef WB_SLAVE_MUX_TIMEOUT_EN
        else if (w_expired) begin
          w_dat_nxt     = DEF_REG_VALUE;
          w_slv_cyc_nxt = 4'b0000;
          w_ack_nxt     = 1'b1;
          w_to_set      = 1'b1;
          w_state_nxt   = S_DONE;
        end else begin
          w_cnt_inc     = 1'b1;
        end
`endif
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_slv_cyc_nxt = 4'b0000;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      r_state   <= S_IDLE;
      r_slv_cyc <= 4'b0000;
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_sel     <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_slv_cyc <= w_slv_cyc_nxt;
      r_ack     <= w_ack_nxt;
      r_dat     <= w_dat_nxt;
      r_sel     <= w_sel_nxt;
    end
  end

`ifdef WB_SLAVE_MUX_TIMEOUT_EN
  // Watchdog counter saturates at 8'hFF rather than wrapping.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      r_cnt <= 8'd0;
    end else if (w_cnt_clr) begin
      r_cnt <= 8'd0;
    end else if (w_cnt_inc && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      r_timeout     <= 1'b0;
      r_timeout_slv <= 2'd0;
    end else if (w_to_set) begin
      r_timeout     <= 1'b1;
      r_timeout_slv <= r_sel;
    end else if (Timeout_Clr_i) begin
      r_timeout     <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_al4s3b_wb_slave_mux.sv
// Directed bench for al4s3b_wb_slave_mux with a read-data scoreboard and behavioural slave models.
module tb_al4s3b_wb_slave_mux;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [9:0]   adr = '0;
  logic         cyc = 1'b0;
  logic         stb = 1'b0;
  logic         we = 1'b0;
  logic [3:0]   bstb = 4'h0;
  logic [31:0]  wdat = '0;
  logic [31:0]  rdat;
  logic         ack;
  logic [9:0]   s_adr;
  logic         s_we;
  logic [3:0]   s_bstb;
  logic [31:0]  s_wdat;
  logic [3:0]   s_cyc;
  logic [3:0]   s_ack;
  logic [127:0] s_dat;
  logic         to;
  logic [1:0]   to_slv;
  logic         to_clr = 1'b0;

  int           n_tests = 0;
  int           n_fail = 0;
  int           ack_cnt = 0;
  logic [31:0]  sb[$];

  logic [3:0]   m_ack_r = 4'h0;
  logic [3:0]   m_force = 4'h0;
  int           m_cnt[4];
  int           m_dly[4];
  logic [31:0]  m_dat[4];

  always #5 clk = ~clk;

  al4s3b_wb_slave_mux #(
    .ADDRWIDTH(10), .DATAWIDTH(32), .TIMEOUT_CYCLES(8'd4), .DEF_REG_VALUE(32'hFABDEFAC)
  ) dut (
    .WBs_CLK_i(clk), .WBs_RSTn_i(rst_n), .WBs_ADR_i(adr), .WBs_CYC_i(cyc), .WBs_STB_i(stb),
    .WBs_WE_i(we), .WBs_BYTE_STB_i(bstb), .WBs_DAT_i(wdat), .WBs_DAT_o(rdat), .WBs_ACK_o(ack),
    .Slv_ADR_o(s_adr), .Slv_WE_o(s_we), .Slv_BYTE_STB_o(s_bstb), .Slv_DAT_o(s_wdat),
    .Slv_CYC_o(s_cyc), .Slv_ACK_i(s_ack), .Slv_DAT_i(s_dat),
    .Timeout_o(to), .Timeout_Slv_o(to_slv), .Timeout_Clr_i(to_clr)
  );

  // Slave n acks once, m_dly[n] cycles after first seeing its CYC.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (s_cyc[i] && !m_ack_r[i]) begin
        if (m_cnt[i] >= m_dly[i]) m_ack_r[i] <= 1'b1;
        m_cnt[i] <= m_cnt[i] + 1;
      end else begin
        m_ack_r[i] <= 1'b0;
        m_cnt[i]   <= 0;
      end
    end
  end

  assign s_ack = m_ack_r | m_force;
  assign s_dat = {m_dat[3], m_dat[2], m_dat[1], m_dat[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ack) begin
      ack_cnt++;
      chk("ack_has_expectation", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("ack_data", rdat, sb.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [9:0] a, input logic w, input logic [31:0] d);
    adr = a; we = w; wdat = d; bstb = 4'hF; cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic drop();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wait_ack(output int e);
    e = 0;
    do begin
      step();
      e++;
    end while (!ack && e < 40);
  endtask

`ifdef WB_SLAVE_MUX_TIMEOUT_EN
  task automatic do_timeout(input logic clr_same);
    int e;
    m_dly[2] = 1000;
    sb.push_back(32'hFABDEFAC);
    req(10'h200, 1'b0, 32'h0);
    e = 0;
    do begin
      step();
      e++;
      if (!ack && clr_same && e == 4) to_clr = 1'b1;
    end while (!ack && e < 40);
    to_clr = 1'b0;
    drop();
    chk("timeout_ack_edge", 32'(e), 32'd5);
    chk("timeout_flag", 32'(to), 32'd1);
    chk("timeout_slv", 32'(to_slv), 32'd2);
  endtask
`endif

  initial begin
    int e;
    int a0;
    logic [3:0] cyc_or;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_dly[i] = 0; m_dat[i] = 32'h0;
    end
    #2;
    chk("rst_slv_cyc", 32'(s_cyc), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_timeout", 32'(to), 32'd0);
    chk("rst_timeout_slv", 32'(to_slv), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Read routing to slave 1, ACK one cycle after CYC.
    m_dat[1] = 32'hA5A50001; m_dly[1] = 0;
    sb.push_back(32'hA5A50001);
    req(10'h104, 1'b0, 32'h0);
    step();
    chk("rd_cyc_e1", 32'(s_cyc), 32'h2);
    chk("rd_ack_e1", 32'(ack), 32'd0);
    step();
    chk("rd_cyc_e2", 32'(s_cyc), 32'h2);
    chk("rd_ack_e2", 32'(ack), 32'd0);
    step();
    chk("rd_cyc_e3", 32'(s_cyc), 32'h0);
    chk("rd_ack_e3", 32'(ack), 32'd1);
    chk("rd_dat_e3", rdat, 32'hA5A50001);
    drop();
    step();
    chk("rd_ack_e4", 32'(ack), 32'd0);
    step();

    // Write to slave 3 while slave 0 holds its ACK high.
    m_dat[3] = 32'h33330003; m_dly[3] = 0; m_force[0] = 1'b1;
    sb.push_back(32'h33330003);
    a0 = ack_cnt;
    cyc_or = 4'h0;
    req(10'h300, 1'b1, 32'h12345678);
    step();
    cyc_or |= s_cyc;
    chk("wr_pass_dat", s_wdat, 32'h12345678);
    chk("wr_pass_we", 32'(s_we), 32'd1);
    chk("wr_pass_adr", 32'(s_adr), 32'h300);
    chk("wr_pass_bstb", 32'(s_bstb), 32'hF);
    for (int k = 0; k < 5; k++) begin
      step();
      cyc_or |= s_cyc;
      if (ack) drop();
    end
    chk("wr_only_slave3", 32'(cyc_or), 32'h8);
    chk("wr_single_ack", 32'(ack_cnt - a0), 32'd1);
    m_force[0] = 1'b0;
    step();

`ifdef WB_SLAVE_MUX_TIMEOUT_EN
    do_timeout(1'b0);
    step();
    to_clr = 1'b1;
    step();
    to_clr = 1'b0;
    chk("timeout_cleared", 32'(to), 32'd0);
    step();
`else
    m_dly[2] = 1000;
    a0 = ack_cnt;
    req(10'h200, 1'b0, 32'h0);
    repeat (20) step();
    chk("nowd_no_ack", 32'(ack_cnt - a0), 32'd0);
    chk("nowd_cyc_held", 32'(s_cyc), 32'h4);
    chk("nowd_timeout_zero", 32'(to), 32'd0);
    drop();
    step();
    chk("nowd_abort_cyc", 32'(s_cyc), 32'h0);
    step();
`endif

    // Slave ACK lands on the edge where the watchdog would expire.
    m_dat[1] = 32'hB0B00001; m_dly[1] = 2;
    sb.push_back(32'hB0B00001);
    req(10'h104, 1'b0, 32'h0);
    wait_ack(e);
    drop();
    chk("late_ack_edge", 32'(e), 32'd5);
    chk("late_ack_dat", rdat, 32'hB0B00001);
    chk("late_ack_no_timeout", 32'(to), 32'd0);
    step(); step();

`ifdef WB_SLAVE_MUX_TIMEOUT_EN
    do_timeout(1'b1);
    step();
`endif

    // Abort: upstream CYC dropped while BUSY.
    m_dly[0] = 1000;
    a0 = ack_cnt;
    req(10'h000, 1'b0, 32'h0);
    step();
    step();
    chk("abort_cyc_busy", 32'(s_cyc), 32'h1);
    drop();
    step();
    chk("abort_cyc_cleared", 32'(s_cyc), 32'h0);
    repeat (6) step();
    chk("abort_no_ack", 32'(ack_cnt - a0), 32'd0);

    // Back-to-back reads to slave 0 then slave 1.
    m_dat[0] = 32'h000000A0; m_dly[0] = 0;
    m_dat[1] = 32'h000000B1; m_dly[1] = 0;
    sb.push_back(32'h000000A0);
    sb.push_back(32'h000000B1);
    req(10'h000, 1'b0, 32'h0);
    wait_ack(e);
    chk("b2b_first_edge", 32'(e), 32'd3);
    req(10'h104, 1'b0, 32'h0);
    step();
    chk("b2b_done_no_cyc", 32'(s_cyc), 32'h0);
    step();
    chk("b2b_second_accepted", 32'(s_cyc), 32'h2);
    wait_ack(e);
    drop();
    chk("b2b_second_edge", 32'(e), 32'd2);
    step(); step();

    // Asynchronous reset in the middle of a BUSY cycle.
    m_dly[2] = 1000;
    a0 = ack_cnt;
    req(10'h200, 1'b0, 32'h0);
    step();
    step();
    chk("rstmid_cyc_busy", 32'(s_cyc), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("rstmid_cyc", 32'(s_cyc), 32'h0);
    chk("rstmid_ack", 32'(ack), 32'd0);
    chk("rstmid_dat", rdat, 32'd0);
    chk("rstmid_timeout", 32'(to), 32'd0);
    chk("rstmid_timeout_slv", 32'(to_slv), 32'd0);
    drop();
    step();
    step();
    rst_n = 1'b1;
    repeat (8) step();
    chk("rstmid_no_ack", 32'(ack_cnt - a0), 32'd0);
    chk("rstmid_cyc_idle", 32'(s_cyc), 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/al4s3b_wb_slave_mux.md
# al4s3b_wb_slave_mux

Wishbone slave-side sequencer between the AHB-to-FPGA bridge and up to four FPGA register/peripheral slaves: the FPGA register file, AEC control, FIFO status and spare. It decodes each bridge cycle to one slave and drives that slave's cycle strobe. It returns that slave's read data and a single registered acknowledge to the bridge. A watchdog terminates any cycle a slave never acknowledges, returning a default value and setting a sticky error flag.

## Interface
- ADDRWIDTH, 10: byte address width; ADR[ADDRWIDTH-1:ADDRWIDTH-2] selects slave 0..3.
- DATAWIDTH, 32: data bus width.
- TIMEOUT_CYCLES, 8'd255: BUSY cycles without slave ACK before forced termination (legal range 1..255).
- DEF_REG_VALUE, 32'hFAB_DEF_AC: read data returned on timeout.
- WBs_CLK_i  in  1  Wishbone clock; all state on rising edge.
- WBs_RSTn_i  in  1  asynchronous, active-low reset.
- WBs_ADR_i / WBs_CYC_i / WBs_STB_i / WBs_WE_i / WBs_BYTE_STB_i[3:0] / WBs_DAT_i  in  as bridge  upstream request.
- WBs_DAT_o  out  DATAWIDTH  upstream read data, registered.
- WBs_ACK_o  out  1  upstream acknowledge, registered, one-cycle pulse.
- Slv_ADR_o, Slv_WE_o, Slv_BYTE_STB_o, Slv_DAT_o  out  as upstream  combinational pass-through of the upstream signals.
- Slv_CYC_o  out  4  per-slave cycle, registered, one-hot or zero; each slave uses it as both CYC and STB.
- Slv_ACK_i  in  4  per-slave acknowledge.
- Slv_DAT_i  in  4*DATAWIDTH  slave read data; slave n at [n*DATAWIDTH +: DATAWIDTH].
- Timeout_o  out  1  sticky timeout flag.
- Timeout_Slv_o  out  2  index of the slave that last timed out.
- Timeout_Clr_i  in  1  synchronous clear of Timeout_o.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: when WBs_CYC_i & WBs_STB_i, latch the slave index sel = ADR[top 2 bits], set Slv_CYC_o[sel], clear the watchdog counter, go to BUSY.
- BUSY, in priority order:
  - WBs_CYC_i low (abort): clear Slv_CYC_o, go to IDLE, no upstream ACK.
  - Slv_ACK_i[sel] high: capture Slv_DAT_i[sel] into WBs_DAT_o, clear Slv_CYC_o, set WBs_ACK_o, go to DONE.
  - Counter equals TIMEOUT_CYCLES-1: capture DEF_REG_VALUE, clear Slv_CYC_o, set WBs_ACK_o, set Timeout_o and Timeout_Slv_o=sel, go to DONE.
  - Otherwise: increment the counter.
- Slave ACK and timeout in the same cycle: the ACK wins; no error is flagged.
- Any ACK on a non-selected slave is ignored.
- DONE: clear WBs_ACK_o, go to IDLE. The bridge drops STB on the edge where it samples ACK, so a new request is accepted no earlier than the cycle after DONE.
- Write cycles take the same path; WBs_DAT_o is still updated with the captured value.
- Timeout_o: Timeout_Clr_i clears it. If a set and Timeout_Clr_i occur in the same cycle, the set wins.
- Counter is 8 bits and saturates; it never wraps.

## Timing
- Reset values: state IDLE, Slv_CYC_o 0, WBs_ACK_o 0, WBs_DAT_o 0, Timeout_o 0, Timeout_Slv_o 0, counter 0. Reset is asynchronous and may occur in any state.
- Typical read, with a slave that acknowledges one cycle after its CYC:
  - Edge 1: request sampled; Slv_CYC_o rises.
  - Edge 2: slave ACK rises.
  - Edge 3: data captured; WBs_ACK_o rises.
  - Edge 4: WBs_ACK_o falls.
  - Upstream ACK is therefore 3 cycles after the request is sampled.
- Slv_CYC_o falls on the same edge the slave's ACK self-clears, so a slave using ack_nxt = cyc&stb&~ack acknowledges exactly once.
- Timeout: WBs_ACK_o rises TIMEOUT_CYCLES+1 edges after the request is sampled.

## Configuration
- WB_SLAVE_MUX_TIMEOUT_EN defined: watchdog, Timeout_o, Timeout_Slv_o and Timeout_Clr_i behave as above.
- Undefined: no counter; BUSY waits indefinitely for the slave ACK or an abort; Timeout_o and Timeout_Slv_o are tied to 0; Timeout_Clr_i is ignored.

## Test plan
- Reset check: drive WBs_RSTn_i low mid-BUSY -> all outputs return to reset values immediately; no ACK follows release.
- Read routing: read ADR=10'h104, slave 1 returns 32'hA5A5_0001 one cycle after CYC -> Slv_CYC_o=4'b0010 for exactly 2 cycles; WBs_DAT_o=32'hA5A5_0001; WBs_ACK_o is a 1-cycle pulse at edge 3.
- Write routing and ACK isolation: write ADR=10'h300, DAT=32'h1234_5678, slave 3 acks while slave 0 holds ACK high throughout -> only slave 3 is strobed; exactly one upstream ACK.
- Timeout: with TIMEOUT_CYCLES=4, read slave 2 with its ACK held low -> ACK at edge 5, WBs_DAT_o=32'hFAB_DEF_AC, Timeout_o=1, Timeout_Slv_o=2. Pulse Timeout_Clr_i -> Timeout_o=0. Repeat the timeout with the clear asserted on the same edge as the set -> Timeout_o stays 1.
- Boundary cases:
  - Slave ACK arriving on the same edge the counter expires -> slave data returned, Timeout_o stays 0.
  - Upstream CYC dropped in BUSY -> Slv_CYC_o cleared, no upstream ACK.
  - Back-to-back reads to slaves 0 then 1 -> second request accepted the cycle after DONE.
